operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand/register width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-004 SHALL have port in_valid  input  1  instruction word valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-006 SHALL have port instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
REQ-007 SHALL have port wb_en  input  1  writeback enable.
REQ-008 SHALL have port wb_addr  input  4  writeback register index.
REQ-009 SHALL have port wb_data  input  16  writeback value.
REQ-010 SHALL have port out_valid  output  1  operand bundle valid toward the ALU.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the bundle.
REQ-012 SHALL have port operation  output  4  ALU operation code.
REQ-013 SHALL have port alu_op1  output  16  first ALU operand.
REQ-014 SHALL have port alu_op2  output  16  second ALU operand.
REQ-015 SHALL have port rd_addr  output  4  destination register carried to writeback.
REQ-016 SHALL have port illegal  output  1  the bundle came from an undefined opcode.
REQ-017 SHALL have port issued_count  output  16  count of accepted instructions.

Function
REQ-018 SHALL hold a 16 x 16-bit register file; R0 reads 0 always; writes to R0 are ignored.
REQ-019 SHALL write wb_data to R[wb_addr] on a rising edge when wb_en=1 and wb_addr!=0.
REQ-020 SHALL read rs1/rs2 with write-through bypass: if wb_en=1, wb_addr==rs, rs!=0 in the capture cycle, wb_data is used.
REQ-021 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-022 SHALL capture a bundle on the edge where in_valid && in_ready; latency 1 cycle; out_valid=1 next cycle.
REQ-023 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-024 SHALL clear out_valid on an edge with out_ready=1 and no capture; simultaneous drain+capture keeps out_valid=1 with the new bundle.
REQ-025 Opcodes 0000-1010: operation=opcode, alu_op1=R[rs1], alu_op2=R[rs2], rd_addr=rd, illegal=0.
REQ-026 Opcode 0011 (NOT): alu_op2 SHALL be 0.
REQ-027 Opcode 1011 (ADDI): operation=1000, alu_op1=R[rs1], alu_op2=zero-extended instr[3:0], rd_addr=rd.
REQ-028 Opcodes 1100-1111: operation=1111, alu_op1=alu_op2=0, rd_addr=0, illegal=1.
REQ-029 SHALL increment issued_count by 1 per accepted instruction (illegal included), wrapping 0xFFFF to 0x0000.

Reset
REQ-030 On an edge with rst=1: out_valid=0, operation=0000, alu_op1=alu_op2=0, rd_addr=0, illegal=0, issued_count=0, R1-R15 cleared to 0.
REQ-031 rst SHALL take priority over capture and writeback in the same cycle; an in-flight bundle is discarded.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-033 Write R3=0x1234, R4=0x0F0F via wb; issue instr 0x0534 -> next cycle operation=0000, alu_op1=0x1234, alu_op2=0x0F0F, rd_addr=5.
REQ-034 Issue 0x8234 while wb_en=1, wb_addr=3, wb_data=0xAAAA in the same cycle -> alu_op1=0xAAAA (bypass); R0 write of 0xFFFF -> reads of R0 return 0.
REQ-035 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, issued_count unchanged; release -> next instruction captured with no bundle lost or duplicated.
REQ-036 Issue 0xB17F (ADDI) -> operation=1000, alu_op2=0x000F, rd_addr=1; issue 0xE123 -> operation=1111, operands 0, rd_addr=0, illegal=1.
REQ-037 Preload issued_count to 0xFFFF via 65535 accepts, accept one more -> 0x0000; assert rst with out_valid=1 -> next cycle out_valid=0, all registers read 0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decodes a 16-bit instruction, reads two operands from a 16 x DATA_W
//   register file (R0 hard-wired to zero, write-through bypass from the
//   writeback port), and presents a registered operand bundle to the ALU
//   through a valid/ready handshake. Also counts accepted instructions.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready instruction handshake (in_ready = !out_valid || out_ready)
//   instr             [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
//   wb_en/addr/data   register file writeback port
//   out_valid/ready   operand bundle handshake toward the ALU
//   operation         ALU operation code
//   alu_op1/alu_op2   ALU operands
//   rd_addr           destination register carried to writeback
//   illegal           bundle came from an undefined opcode
//   issued_count      wrapping count of accepted instructions
module operand_fetch_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        operation,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        rd_addr,
  output logic              illegal,
  output logic [15:0]       issued_count
);

  localparam logic [3:0] OPC_NOT  = 4'b0011;
  localparam logic [3:0] OPC_ADD  = 4'b1000;
  localparam logic [3:0] OPC_ADDI = 4'b1011;
  localparam logic [3:0] OPC_ILL  = 4'b1111;

  logic [DATA_W-1:0] regs [16];

  // Register read with write-through bypass; R0 always reads as zero.
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [3:0]        addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp_en,
    input logic [3:0]        byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    logic [DATA_W-1:0] r;
    if (addr == 4'd0)
      r = '0;
    else if (byp_en && (byp_addr == addr))
      r = byp_data;
    else
      r = stored;
    return r;
  endfunction

  // Stage 0: decode and operand read (combinational)
  logic [3:0]        opc_p0;
  logic [3:0]        rs1_p0;
  logic [3:0]        rs2_p0;
  logic [DATA_W-1:0] rs1_val_p0;
  logic [DATA_W-1:0] rs2_val_p0;
  logic [3:0]        op_p0;
  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic [3:0]        rd_p0;
  logic              ill_p0;
  logic              capture;

  assign opc_p0     = instr[15:12];
  assign rs1_p0     = instr[7:4];
  assign rs2_p0     = instr[3:0];
  assign rs1_val_p0 = read_reg(rs1_p0, regs[rs1_p0], wb_en, wb_addr, wb_data);
  assign rs2_val_p0 = read_reg(rs2_p0, regs[rs2_p0], wb_en, wb_addr, wb_data);

  always_comb begin
    op_p0  = opc_p0;
    op1_p0 = rs1_val_p0;
    op2_p0 = rs2_val_p0;
    rd_p0  = instr[11:8];
    ill_p0 = 1'b0;
    if (opc_p0 == OPC_NOT) begin
      op2_p0 = '0;
    end else if (opc_p0 == OPC_ADDI) begin
      op_p0  = OPC_ADD;
      op2_p0 = {{(DATA_W-4){1'b0}}, instr[3:0]};
    end else if (opc_p0[3:2] == 2'b11) begin
      op_p0  = OPC_ILL;
      op1_p0 = '0;
      op2_p0 = '0;
      rd_p0  = 4'd0;
      ill_p0 = 1'b1;
    end
  end

  logic              vld_p1;
  logic [3:0]        op_p1;
  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic [3:0]        rd_p1;
  logic              ill_p1;
  logic [15:0]       cnt_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign capture  = in_valid && in_ready;

  // Register file: reset wins over writeback; R0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 4'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Stage 1: registered operand bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      op_p1  <= 4'd0;
      op1_p1 <= '0;
      op2_p1 <= '0;
      rd_p1  <= 4'd0;
      ill_p1 <= 1'b0;
      cnt_p1 <= 16'd0;
    end else if (capture) begin
      vld_p1 <= 1'b1;
      op_p1  <= op_p0;
      op1_p1 <= op1_p0;
      op2_p1 <= op2_p0;
      rd_p1  <= rd_p0;
      ill_p1 <= ill_p0;
      cnt_p1 <= cnt_p1 + 16'd1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign operation    = op_p1;
  assign alu_op1      = op1_p1;
  assign alu_op2      = op2_p1;
  assign rd_addr      = rd_p1;
  assign illegal      = ill_p1;
  assign issued_count = cnt_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  operation;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [3:0]  rd_addr;
  logic        illegal;
  logic [15:0] issued_count;

  operand_fetch_stage #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .rd_addr(rd_addr),
    .illegal(illegal), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  op;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  rd;
    logic        ill;
  } vec_t;

  vec_t        tv [10];
  int          passed = 0;
  int          total  = 0;
  logic [15:0] exp_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic check_bundle(input string tag, input logic [3:0] op, input logic [15:0] op1,
                              input logic [15:0] op2, input logic [3:0] rd, input logic ill);
    check({tag, ".operation"}, {12'd0, operation}, {12'd0, op});
    check({tag, ".alu_op1"}, alu_op1, op1);
    check({tag, ".alu_op2"}, alu_op2, op2);
    check({tag, ".rd_addr"}, {12'd0, rd_addr}, {12'd0, rd});
    check({tag, ".illegal"}, {15'd0, illegal}, {15'd0, ill});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 16'h0; wb_en = 1'b0;
    wb_addr = 4'h0; wb_data = 16'h0; out_ready = 1'b1;

    //            instr    wb  addr  data      op     op1       op2       rd    ill
    tv[0] = '{16'h0534, 1'b0, 4'h0, 16'h0000, 4'h0, 16'h1234, 16'h0F0F, 4'h5, 1'b0};
    tv[1] = '{16'h8234, 1'b1, 4'h3, 16'hAAAA, 4'h8, 16'hAAAA, 16'h0F0F, 4'h2, 1'b0};
    tv[2] = '{16'h3134, 1'b0, 4'h0, 16'h0000, 4'h3, 16'hAAAA, 16'h0000, 4'h1, 1'b0};
    tv[3] = '{16'hB17F, 1'b0, 4'h0, 16'h0000, 4'h8, 16'h0707, 16'h000F, 4'h1, 1'b0};
    tv[4] = '{16'hE123, 1'b0, 4'h0, 16'h0000, 4'hF, 16'h0000, 16'h0000, 4'h0, 1'b1};
    tv[5] = '{16'h1A00, 1'b0, 4'h0, 16'h0000, 4'h1, 16'h0000, 16'h0000, 4'hA, 1'b0};
    tv[6] = '{16'h2F01, 1'b1, 4'h0, 16'hFFFF, 4'h2, 16'h0000, 16'h1111, 4'hF, 1'b0};
    tv[7] = '{16'hA921, 1'b0, 4'h0, 16'h0000, 4'hA, 16'h2222, 16'h1111, 4'h9, 1'b0};
    tv[8] = '{16'hC000, 1'b0, 4'h0, 16'h0000, 4'hF, 16'h0000, 16'h0000, 4'h0, 1'b1};
    tv[9] = '{16'h5340, 1'b1, 4'h4, 16'h5555, 4'h5, 16'h5555, 16'h0000, 4'h3, 1'b0};

    step(); step();
    rst = 1'b0;
    #1;
    check("reset.out_valid", {15'd0, out_valid}, 16'd0);
    check("reset.in_ready", {15'd0, in_ready}, 16'd1);
    check("reset.count", issued_count, 16'd0);
    check_bundle("reset", 4'h0, 16'h0, 16'h0, 4'h0, 1'b0);

    wb_write(4'h3, 16'h1234);
    wb_write(4'h4, 16'h0F0F);
    wb_write(4'h0, 16'hFFFF);
    wb_write(4'h1, 16'h1111);
    wb_write(4'h2, 16'h2222);
    wb_write(4'h7, 16'h0707);

    exp_cnt = 16'd0;
    for (int i = 0; i < 10; i++) begin
      instr = tv[i].instr; in_valid = 1'b1;
      wb_en = tv[i].wb_en; wb_addr = tv[i].wb_addr; wb_data = tv[i].wb_data;
      step();
      in_valid = 1'b0; wb_en = 1'b0;
      exp_cnt++;
      check($sformatf("vec%0d.out_valid", i), {15'd0, out_valid}, 16'd1);
      check_bundle($sformatf("vec%0d", i), tv[i].op, tv[i].op1, tv[i].op2, tv[i].rd, tv[i].ill);
      check($sformatf("vec%0d.count", i), issued_count, exp_cnt);
    end
    step();
    check("drain.out_valid", {15'd0, out_valid}, 16'd0);

    // Backpressure: R3=AAAA, R4=5555, R1=1111, R2=2222 at this point.
    out_ready = 1'b0;
    instr = 16'h0534; in_valid = 1'b1;
    step();
    exp_cnt++;
    instr = 16'h6112;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d.in_ready", k), {15'd0, in_ready}, 16'd0);
      check($sformatf("stall%0d.out_valid", k), {15'd0, out_valid}, 16'd1);
      check_bundle($sformatf("stall%0d", k), 4'h0, 16'hAAAA, 16'h5555, 4'h5, 1'b0);
      check($sformatf("stall%0d.count", k), issued_count, exp_cnt);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", {15'd0, in_ready}, 16'd1);
    step();
    exp_cnt++;
    in_valid = 1'b0;
    check("release.out_valid", {15'd0, out_valid}, 16'd1);
    check_bundle("release", 4'h6, 16'h1111, 16'h2222, 4'h1, 1'b0);
    check("release.count", issued_count, exp_cnt);
    step();
    check("release_drain.out_valid", {15'd0, out_valid}, 16'd0);
    check("release_drain.count", issued_count, exp_cnt);

    // Counter wrap, then reset with a bundle in flight.
    rst = 1'b1; step(); rst = 1'b0;
    wb_write(4'h6, 16'h6666);
    instr = 16'h0660; in_valid = 1'b1;
    for (int n = 0; n < 65535; n++) step();
    check("wrap.count_ffff", issued_count, 16'hFFFF);
    step();
    check("wrap.count_0000", issued_count, 16'h0000);
    check("wrap.out_valid", {15'd0, out_valid}, 16'd1);
    check("wrap.alu_op1", alu_op1, 16'h6666);
    wb_en = 1'b1; wb_addr = 4'h7; wb_data = 16'hBEEF;
    rst = 1'b1;
    step();
    rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    check("rst_flight.out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_flight.count", issued_count, 16'd0);
    check_bundle("rst_flight", 4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
    check("rst_flight.in_ready", {15'd0, in_ready}, 16'd1);
    instr = 16'h0067; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_bundle("post_rst_read", 4'h0, 16'h0000, 16'h0000, 4'h0, 1'b0);
    check("post_rst_read.count", issued_count, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
